// File: rtl/mul_pkg.sv
// Shared defaults and width helpers for the pipelined Karatsuba multiplier.
package mul_pkg;

  localparam int DEF_W     = 255;
  localparam int DEF_TAG_W = 4;

  // High-half product: both high halves are (w-k) bits wide.
  function automatic int h_width(input int w, input int k);
    return 2 * (w - k);
  endfunction

  function automatic int l_width(input int k);
    return 2 * k;
  endfunction

  // Product of two (k+1)-bit half sums.
  function automatic int m_width(input int k);
    return 2 * k + 2;
  endfunction

  function automatic int p_width(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/kara_recombine.sv
// Combinational Karatsuba recombination: P = (H << 2K) + ((M - H - L) << K) + L.
module kara_recombine
  import mul_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int K = (W + 1) / 2
) (
  input  logic [h_width(W, K)-1:0] h_i,
  input  logic [l_width(K)-1:0]    l_i,
  input  logic [m_width(K)-1:0]    m_i,
  output logic [p_width(W)-1:0]    p_o
);

  localparam int M_W = m_width(K);
  localparam int P_W = p_width(W);

  // M - H - L equals A1*B2 + A2*B1, so it never goes negative and fits in M_W bits.
  logic [M_W-1:0] w_mid;

  assign w_mid = m_i - M_W'(h_i) - M_W'(l_i);
  assign p_o   = (P_W'(h_i) << (2 * K)) + (P_W'(w_mid) << K) + P_W'(l_i);

endmodule

// File: rtl/karatsuba_mul_pipe.sv
// Three-stage pipelined Karatsuba multiplier with tag passthrough.
// Define KARATSUBA_RAW_PARTIALS_EN to also export the registered H/L/M partial products.
module karatsuba_mul_pipe
  import mul_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int K     = (W + 1) / 2,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             x_i,
  input  logic [W-1:0]             y_i,
  input  logic [TAG_W-1:0]         tag_i,
  output logic [TAG_W-1:0]         tag_o,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [p_width(W)-1:0]    p_o
`ifdef KARATSUBA_RAW_PARTIALS_EN
  ,
  output logic [h_width(W, K)-1:0] h_o,
  output logic [l_width(K)-1:0]    l_o,
  output logic [m_width(K)-1:0]    m_o
`endif
);

  localparam int HI_W  = W - K;
  localparam int SUM_W = K + 1;
  localparam int H_W   = h_width(W, K);
  localparam int L_W   = l_width(K);
  localparam int M_W   = m_width(K);
  localparam int P_W   = p_width(W);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // Every stage moves together on w_adv; in_ready never looks at in_valid.
  logic w_adv;

  logic             r_v1, r_v2, r_v3;
  logic [K-1:0]     r_a1, r_b1;
  logic [HI_W-1:0]  r_a2, r_b2;
  logic [SUM_W-1:0] r_sa, r_sb;
  logic [TAG_W-1:0] r_tag1, r_tag2, r_tag3;
  logic [H_W-1:0]   r_h;
  logic [L_W-1:0]   r_l;
  logic [M_W-1:0]   r_m;
  logic [P_W-1:0]   r_p;
  logic [P_W-1:0]   w_p;

  assign w_adv     = !r_v3 || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_v3;
  assign p_o       = r_p;
  assign tag_o     = r_tag3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (w_adv) begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end

  // S1/S2 datapath carries no reset; its content only matters behind a set valid bit.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_a1   <= x_i[K-1:0];
      r_a2   <= x_i[W-1:K];
      r_b1   <= y_i[K-1:0];
      r_b2   <= y_i[W-1:K];
      r_sa   <= SUM_W'(x_i[K-1:0]) + SUM_W'(x_i[W-1:K]);
      r_sb   <= SUM_W'(y_i[K-1:0]) + SUM_W'(y_i[W-1:K]);
      r_tag1 <= tag_i;
      r_h    <= H_W'(r_a2) * H_W'(r_b2);
      r_l    <= L_W'(r_a1) * L_W'(r_b1);
      r_m    <= M_W'(r_sa) * M_W'(r_sb);
      r_tag2 <= r_tag1;
    end
  end

  kara_recombine #(
    .W (W),
    .K (K)
  ) u_recombine (
    .h_i (r_h),
    .l_i (r_l),
    .m_i (r_m),
    .p_o (w_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p    <= '0;
      r_tag3 <= '0;
    end else if (w_adv) begin
      r_p    <= w_p;
      r_tag3 <= r_tag2;
    end
  end

`ifdef KARATSUBA_RAW_PARTIALS_EN
  logic [H_W-1:0] r_h3;
  logic [L_W-1:0] r_l3;
  logic [M_W-1:0] r_m3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h3 <= '0;
      r_l3 <= '0;
      r_m3 <= '0;
    end else if (w_adv) begin
      r_h3 <= r_h;
      r_l3 <= r_l;
      r_m3 <= r_m;
    end
  end

  assign h_o = r_h3;
  assign l_o = r_l3;
  assign m_o = r_m3;
`endif

endmodule

// File: tb/tb_karatsuba_mul_pipe.sv
// Bench for karatsuba_mul_pipe: directed W=255 vectors and sequences, plus an
// exhaustive W=8 sweep split across two instances. Honours KARATSUBA_RAW_PARTIALS_EN.
module tb_karatsuba_mul_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- W=255 instance ----------------
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [254:0] x_i, y_i;
  logic [3:0]   tag_i, tag_o;
  logic [509:0] p_o;
`ifdef KARATSUBA_RAW_PARTIALS_EN
  logic [253:0] h_o;
  logic [255:0] l_o;
  logic [257:0] m_o;
`endif

  karatsuba_mul_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_i       (x_i),
    .y_i       (y_i),
    .tag_i     (tag_i),
    .tag_o     (tag_o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p_o       (p_o)
`ifdef KARATSUBA_RAW_PARTIALS_EN
    ,
    .h_o       (h_o),
    .l_o       (l_o),
    .m_o       (m_o)
`endif
  );

  // ---------------- two W=8 lanes ----------------
  logic       s_iv [2];
  logic       s_ir [2];
  logic       s_ov [2];
  logic       s_or [2];
  logic [7:0] s_x  [2];
  logic [7:0] s_y  [2];
  logic [3:0] s_tg [2];
  logic [3:0] s_to [2];
  logic [15:0] s_p [2];
`ifdef KARATSUBA_RAW_PARTIALS_EN
  logic [7:0] s_h [2];
  logic [7:0] s_l [2];
  logic [9:0] s_m [2];
`endif

  for (genvar g = 0; g < 2; g++) begin : g_lane
    karatsuba_mul_pipe #(.W(8), .TAG_W(4)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s_iv[g]),
      .in_ready  (s_ir[g]),
      .x_i       (s_x[g]),
      .y_i       (s_y[g]),
      .tag_i     (s_tg[g]),
      .tag_o     (s_to[g]),
      .out_valid (s_ov[g]),
      .out_ready (s_or[g]),
      .p_o       (s_p[g])
`ifdef KARATSUBA_RAW_PARTIALS_EN
      ,
      .h_o       (s_h[g]),
      .l_o       (s_l[g]),
      .m_o       (s_m[g])
`endif
    );
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [513:0] exp_q  [$];
  logic [45:0]  exp8_q0 [$];
  logic [45:0]  exp8_q1 [$];

  logic [509:0] last_p;
  logic [3:0]   last_tag;

  task automatic check(input string nm, input logic [599:0] act, input logic [599:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // ---------------- reference models ----------------
  function automatic logic [509:0] mul255(input logic [254:0] a, input logic [254:0] b);
    logic [509:0] ea, eb;
    ea = {255'b0, a};
    eb = {255'b0, b};
    return ea * eb;
  endfunction

  function automatic logic [254:0] rand255();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r[254:0];
  endfunction

  // {tag, product, H, L, M}; partial fields stay zero when not exported
  function automatic logic [45:0] model8(input int x, input int y, input logic [3:0] tg);
    int a1, a2, b1, b2, pr, h, l, m;
    a1 = x % 16; a2 = x / 16;
    b1 = y % 16; b2 = y / 16;
    pr = x * y;
    h  = a2 * b2;
    l  = a1 * b1;
    m  = (a1 + a2) * (b1 + b2);
`ifdef KARATSUBA_RAW_PARTIALS_EN
    return {tg, 16'(pr), 8'(h), 8'(l), 10'(m)};
`else
    if (h + l + m < 0) return '1;
    return {tg, 16'(pr), 26'b0};
`endif
  endfunction

  function automatic logic [45:0] actual8(input int j);
`ifdef KARATSUBA_RAW_PARTIALS_EN
    return {s_to[j], s_p[j], s_h[j], s_l[j], s_m[j]};
`else
    return {s_to[j], s_p[j], 26'b0};
`endif
  endfunction

  // ---------------- W=255 driver ----------------
  task automatic step(input bit iv, input bit ordy, input logic [254:0] x, input logic [254:0] y,
                      input logic [3:0] tg, output bit acc, output bit ret);
    logic [513:0] e;
    @(negedge clk);
    in_valid  = iv;
    x_i       = x;
    y_i       = y;
    tag_i     = tg;
    out_ready = ordy;
    #1;
    acc = iv && in_ready;
    ret = out_valid && ordy;
    if (acc) exp_q.push_back({tg, mul255(x, y)});
    if (ret) begin
      last_p   = p_o;
      last_tag = tag_o;
      if (exp_q.size() == 0) check("spurious_out", 600'(out_valid), 600'(0));
      else begin
        e = exp_q.pop_front();
        check("result", {tag_o, p_o}, 600'(e));
      end
    end
  endtask

  typedef struct {
    logic [254:0] x;
    logic [254:0] y;
    logic [3:0]   tag;
    logic [509:0] p;
  } vec_t;

  vec_t vecs [7];

  initial begin
    bit acc, ret;
    int lat, nacc, nret, first_ret, last_ret, idx [2], cyc;
    logic [254:0] max_v, px, py, tmp;
    logic [509:0] stall_p, pe;
    logic [3:0] pt;

    rst = 1'b1; in_valid = 0; out_ready = 0; x_i = '0; y_i = '0; tag_i = '0;
    for (int j = 0; j < 2; j++) begin
      s_iv[j] = 0; s_or[j] = 0; s_x[j] = '0; s_y[j] = '0; s_tg[j] = '0;
    end

    // reset state
    #1;
    check("rst_out_valid", 600'(out_valid), 600'(0));
    check("rst_p", 600'(p_o), 600'(0));
    check("rst_tag", 600'(tag_o), 600'(0));
    check("rst_in_ready", 600'(in_ready), 600'(1));
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // directed table
    max_v = '1;
    vecs[0] = '{x: 255'd3, y: 255'd5, tag: 4'hA, p: 510'd15};
    vecs[1] = '{x: max_v, y: max_v, tag: 4'h5, p: {{254{1'b1}}, {255{1'b0}}, 1'b1}};
    vecs[2] = '{x: '0, y: max_v, tag: 4'h3, p: '0};
    vecs[3] = '{x: max_v, y: 255'd1, tag: 4'h7, p: {255'b0, max_v}};
    tmp = '0; tmp[254] = 1'b1; pe = '0; pe[255] = 1'b1;
    vecs[4] = '{x: tmp, y: 255'd2, tag: 4'hC, p: pe};
    tmp = '0; tmp[127:0] = '1;
    vecs[5] = '{x: tmp, y: tmp, tag: 4'h1, p: {254'b0, {127{1'b1}}, {128{1'b0}}, 1'b1}};
    tmp = '0; tmp[128] = 1'b1; pe = '0; pe[256] = 1'b1;
    vecs[6] = '{x: tmp, y: tmp, tag: 4'hF, p: pe};

    for (int v = 0; v < 7; v++) begin
      step(1, 1, vecs[v].x, vecs[v].y, vecs[v].tag, acc, ret);
      check("tbl_accept", 600'(acc), 600'(1));
      lat = 0;
      ret = 0;
      while (!ret && lat < 10) begin
        step(0, 1, '0, '0, '0, acc, ret);
        lat++;
      end
      check("tbl_latency", 600'(lat), 600'(3));
      check("tbl_p", 600'(last_p), 600'(vecs[v].p));
      check("tbl_tag", 600'(last_tag), 600'(vecs[v].tag));
    end

    // 10 back-to-back ops, tags 0..9
    nret = 0; first_ret = -1; last_ret = -1;
    for (int c = 0; c < 22; c++) begin
      if (c < 10) step(1, 1, rand255(), rand255(), 4'(c), acc, ret);
      else        step(0, 1, '0, '0, '0, acc, ret);
      if (c < 10) check("b2b_accept", 600'(acc), 600'(1));
      if (ret) begin
        check("b2b_tag", 600'(last_tag), 600'(nret));
        if (first_ret < 0) first_ret = c;
        last_ret = c;
        nret++;
      end
    end
    check("b2b_count", 600'(nret), 600'(10));
    check("b2b_first", 600'(first_ret), 600'(3));
    check("b2b_span", 600'(last_ret - first_ret), 600'(9));

    // backpressure: out_ready low for 6 cycles with in_valid high
    nacc = 0; stall_p = '0;
    px = rand255(); py = rand255(); pt = 4'd0;
    for (int c = 0; c < 6; c++) begin
      step(1, 0, px, py, pt, acc, ret);
      if (acc) begin nacc++; px = rand255(); py = rand255(); pt = pt + 4'd1; end
      if (c == 3) begin
        check("bp_out_valid", 600'(out_valid), 600'(1));
        stall_p = p_o;
      end
    end
    check("bp_accepted", 600'(nacc), 600'(3));
    check("bp_in_ready", 600'(in_ready), 600'(0));
    check("bp_hold_p", 600'(p_o), 600'(stall_p));
    check("bp_hold_tag", 600'(tag_o), 600'(0));
    nret = 0;
    for (int c = 0; c < 8; c++) begin
      step(1, 1, px, py, pt, acc, ret);
      if (acc) begin px = rand255(); py = rand255(); pt = pt + 4'd1; end
      if (ret) nret++;
    end
    check("bp_release_rate", 600'(nret), 600'(8));
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) step(0, 1, '0, '0, '0, acc, ret);
    check("bp_drained", 600'(exp_q.size()), 600'(0));

    // random out_ready stream
    for (int c = 0; c < 40; c++) step($urandom_range(1), $urandom_range(1), rand255(), rand255(),
                                     4'($urandom_range(15)), acc, ret);
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) step(0, 1, '0, '0, '0, acc, ret);
    check("rnd_drained", 600'(exp_q.size()), 600'(0));

    // reset mid-operation with a result waiting at the output
    for (int c = 0; c < 3; c++) step(1, 0, rand255() | 255'd1, rand255() | 255'd1, 4'hE, acc, ret);
    step(0, 0, '0, '0, '0, acc, ret);
    check("mid_out_valid_pre", 600'(out_valid), 600'(1));
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 600'(out_valid), 600'(0));
    check("mid_rst_p", 600'(p_o), 600'(0));
    check("mid_rst_tag", 600'(tag_o), 600'(0));
    check("mid_rst_in_ready", 600'(in_ready), 600'(1));
    exp_q.delete();
    @(negedge clk);
    #1;
    check("rst_hold_in_ready", 600'(in_ready), 600'(1));
    rst = 1'b0;
    step(0, 1, '0, '0, '0, acc, ret);
    check("post_rst_in_ready", 600'(in_ready), 600'(1));
    for (int c = 0; c < 8; c++) step(0, 1, '0, '0, '0, acc, ret);
    in_valid = 0;

    // exhaustive W=8 sweep: lane j covers x in [128*j, 128*j+127]
    idx[0] = 0; idx[1] = 0; cyc = 0;
    while ((idx[0] < 32768 || idx[1] < 32768 || exp8_q0.size() > 0 || exp8_q1.size() > 0)
           && cyc < 60000) begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        s_or[j] = ($urandom_range(7) != 0);
        s_iv[j] = (idx[j] < 32768) && ($urandom_range(15) != 0);
        s_x[j]  = 8'(j * 128 + idx[j] / 256);
        s_y[j]  = 8'(idx[j] % 256);
        s_tg[j] = 4'(idx[j] % 16);
      end
      #1;
      for (int j = 0; j < 2; j++) begin
        if (s_ov[j] && s_or[j]) begin
          if (j == 0 && exp8_q0.size() > 0) check("sweep_lane0", 600'(actual8(0)), 600'(exp8_q0.pop_front()));
          else if (j == 1 && exp8_q1.size() > 0) check("sweep_lane1", 600'(actual8(1)), 600'(exp8_q1.pop_front()));
          else check("sweep_spurious", 600'(s_ov[j]), 600'(0));
        end
        if (s_iv[j] && s_ir[j]) begin
          if (j == 0) exp8_q0.push_back(model8(int'(s_x[0]), int'(s_y[0]), s_tg[0]));
          else        exp8_q1.push_back(model8(int'(s_x[1]), int'(s_y[1]), s_tg[1]));
          idx[j]++;
        end
      end
      cyc++;
    end
    if (cyc >= 60000) check("sweep_timeout", 600'(cyc), 600'(0));
    check("sweep_lane0_done", 600'(idx[0]), 600'(32768));
    check("sweep_lane1_done", 600'(idx[1]), 600'(32768));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/karatsuba_mul_pipe.md
KARATSUBA_MUL_PIPE -- requirements
Module: karatsuba_mul_pipe

Interface
REQ-001 SHALL have parameter W, default 255: operand width in bits; legal range 8..512.
REQ-002 SHALL have parameter K, default (W+1)/2: split point; low halves are K bits, high halves are W-K bits.
REQ-003 SHALL have parameter TAG_W, default 4: width of the sideband tag carried with each operation.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1): input handshake.
REQ-007 SHALL have ports x_i and y_i (input, W each): unsigned operands.
REQ-008 SHALL have ports tag_i (input, TAG_W) and tag_o (output, TAG_W): tag passthrough.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1): output handshake.
REQ-010 SHALL have port p_o, output, 2W bits: the full product x_i*y_i.

Function
REQ-011 SHALL accept an operation when in_valid && in_ready on a rising edge.
REQ-012 SHALL complete each operation in three stages:
- S1 registers the halves A1, A2, B1, B2 and the sums SA = A1+A2 and SB = B1+B2, each K+1 bits.
- S2 registers H = A2*B2 (2(W-K) bits), L = A1*B1 (2K bits) and M = SA*SB (2K+2 bits).
- S3 registers p_o = (H<<2K) + ((M-H-L)<<K) + L.
REQ-013 SHALL compute M-H-L in 2K+2 bits; the result is non-negative and exact, and no wrap is permitted.
REQ-014 SHALL present p_o and tag_o exactly 3 cycles after acceptance when out_ready is held high.
REQ-015 SHALL sustain a throughput of one operation per cycle with no bubbles while out_ready=1.
REQ-016 SHALL use a single global advance enable, adv = !out_valid || out_ready; all three stages shift only when adv=1.
REQ-017 SHALL drive in_ready = adv combinationally; in_ready SHALL NOT depend on in_valid.
REQ-018 SHALL carry a per-stage valid bit, so that a bubble accepted into S1 propagates as a bubble.
REQ-019 SHALL hold p_o, tag_o and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL deliver results in acceptance order, with none lost or duplicated under any out_ready pattern.
REQ-021 SHALL leave data registers unchanged when their stage is not advancing; their content while invalid is don't-care except at reset.
REQ-022 SHALL handle out_ready=1 and in_valid=1 in the same cycle with a full pipe by retiring and accepting in that same cycle.

Reset
REQ-023 SHALL clear all stage valid bits, out_valid, p_o and tag_o to 0 while rst=1, asynchronously.
REQ-024 SHALL discard all in-flight operations on reset assertion mid-operation; no partial result is ever output.
REQ-025 SHALL keep in_ready at 1 during reset and in the first cycle after it; acceptance is gated by rst=0.

Configuration
REQ-026 SHALL support the macro KARATSUBA_RAW_PARTIALS_EN:
- Defined: adds outputs h_o, l_o, m_o (widths as in REQ-012), registered in S3, aligned with out_valid and stalled with p_o, and cleared by reset. These are for downstream modular-reduction blocks.
- Undefined: these ports and their S3 registers SHALL NOT exist; p_o behaviour is identical in both builds.

Structure
REQ-027 SHALL take shared constants from package mul_pkg: default W=255, TAG_W=4, and width helpers for H/L/M/P.
REQ-028 SHALL place the S3 recombination shift-add in sub-module kara_recombine (combinational, parameterised by W and K).

Verification
REQ-029 SHALL be covered by these directed scenarios:
- W=255, x=3, y=5, tag=0xA, out_ready=1 -> p_o=15, tag_o=0xA, out_valid exactly 3 cycles after acceptance.
- x=y=2^255-1 -> p_o=2^510-2^256+1; x=0, y=2^255-1 -> p_o=0.
- 10 back-to-back ops with tags 0..9, out_ready=1 -> 10 consecutive out_valid cycles, tags in order 0..9.
- Backpressure: out_ready=0 for 6 cycles with in_valid=1 -> exactly 3 accepted, in_ready=0 afterwards, p_o held stable. On release, results drain in order and throughput returns to 1/cycle.
- Reset mid-operation: assert rst with 2 ops in flight -> out_valid=0 and p_o=0 immediately; neither op ever appears.
- Exhaustive sweep at W=8 (K=4) over all 65536 x,y pairs with random out_ready, both with and without KARATSUBA_RAW_PARTIALS_EN -> p_o matches the reference model and h_o/l_o/m_o match A2*B2, A1*B1, SA*SB.
